// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: a WIDTH-bit adder that reuses one 4-bit CLA slice
// over WIDTH/4 cycles, least significant nibble first. The carry between
// nibbles is held in a register. Operands come in and results go out over
// valid/ready handshakes.
//
// Optional feature: define CLA_SEQ_OVERFLOW_EN to add the `ovf` output.
// `ovf` is a registered two's-complement overflow flag. It is computed from
// the latched operands and follows the same valid/hold rules as `sum`.
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_SEQ_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / 4;
  // One extra bit so the counter type never wraps, even when NIBBLES is a power of two.
  localparam int CW = $clog2(NIBBLES) + 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  // Refuse to build with a width the nibble slicing cannot cover exactly.
  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;
`ifdef CLA_SEQ_OVERFLOW_EN
  logic             ovf_reg;
`endif

  // Nibble views of the latched operands. The slice is fed only from registers.
  logic [3:0] a_nib [NIBBLES];
  logic [3:0] b_nib [NIBBLES];

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nib[gi] = a_reg[4*gi +: 4];
    assign b_nib[gi] = b_reg[4*gi +: 4];
  end

  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [3:0] slice_s;
  logic       slice_c;

  // Steer the nibble selected by the counter into the shared slice.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_reg == CW'(i)) begin
        slice_a = a_nib[i];
        slice_b = b_nib[i];
      end
    end
  end

  cla_4bit u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_reg),
    .s     (slice_s),
    .c_out (slice_c)
  );

  // Control FSM with its datapath registers. The handshake outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      cnt_reg       <= '0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef CLA_SEQ_OVERFLOW_EN
      ovf_reg       <= 1'b0;
`endif
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            carry_reg    <= cin;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          // Write the current nibble of the sum. The other nibbles keep their values.
          for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_reg == CW'(i)) begin
              sum_reg[4*i +: 4] <= slice_s;
            end
          end
          carry_reg <= slice_c;
          if (cnt_reg == LAST_NIB) begin
            cout_reg      <= slice_c;
`ifdef CLA_SEQ_OVERFLOW_EN
            // slice_s[3] is the final sum MSB on this cycle.
            ovf_reg       <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ slice_s[3] ^ slice_c;
`endif
            cnt_reg       <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
`ifdef CLA_SEQ_OVERFLOW_EN
  assign ovf       = ovf_reg;
`endif

endmodule

// cla_4bit: a 4-bit carry-lookahead slice. Every carry is written out as a
// flat generate/propagate equation, so no carry ripples between bits.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  assign g  = a & b;
  assign p  = a ^ b;
  assign c1 = g[0] | (p[0] & c_in);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s     = p ^ {c3, c2, c1, c_in};
  assign c_out = c4;

endmodule
